// File: rtl/spe_pulse_injector_if.sv
// Request channel of the SPE test-pulse injector.
// The requester (master) offers a start timestamp and a peak amplitude.
// The injector (slave) accepts the request or rejects it for one cycle.
interface spe_pulse_injector_if #(
    parameter int RESOLUTION = 4,
    parameter int INBITS     = 14
);
    logic                    t_valid;
    logic                    t_ready;
    logic [33+RESOLUTION:0]  t_in;
    logic [INBITS-1:0]       amp_in;
    logic                    reject;

    modport master (
        output t_valid,
        output t_in,
        output amp_in,
        input  t_ready,
        input  reject
    );

    modport slave (
        input  t_valid,
        input  t_in,
        input  amp_in,
        output t_ready,
        output reject
    );
endinterface

// File: rtl/spe_pulse_injector.sv
// SPE-like test-pulse source for the CFD time extractor sample interface.
// A request carries a start time {group, sample idx, frac} and a peak amplitude.
// When ltc reaches that group, a triangular pulse (linear rise over 2^RISE_LOG2
// samples, linear fall over 2^FALL_LOG2 samples) is drawn on four parallel
// sample lanes, with a per-sample time-over-threshold flag.
// Pipeline: stage 1 holds per-lane time offsets d, stage 2 holds the samples.
module spe_pulse_injector #(
    parameter int INBITS     = 14,
    parameter int RESOLUTION = 4,
    parameter int RISE_LOG2  = 1,
    parameter int FALL_LOG2  = 3,
    parameter int BASELINE   = 8192,
    parameter int TOT_THRESH = 100
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [31:0]             ltc,
    spe_pulse_injector_if.slave     req,
    output logic                    busy,
    output logic [31:0]             ltc_out,
    output logic [INBITS-1:0]       out_0,
    output logic [INBITS-1:0]       out_1,
    output logic [INBITS-1:0]       out_2,
    output logic [INBITS-1:0]       out_3,
    output logic                    tot_0,
    output logic                    tot_1,
    output logic                    tot_2,
    output logic                    tot_3
);

    // Time word width: {group[31:0], idx[1:0], frac}
    localparam int W      = 34 + RESOLUTION;
    localparam int RS     = RISE_LOG2 + RESOLUTION;
    localparam int FS     = FALL_LOG2 + RESOLUTION;
    // Magnitude width large enough for d on the rise and E-d on the fall
    localparam int DW     = ((RISE_LOG2 > FALL_LOG2) ? RISE_LOG2 : FALL_LOG2) + RESOLUTION + 1;
    localparam int PW     = INBITS + DW;

    localparam logic signed [W-1:0] P_C    = W'(2**RS);
    localparam logic signed [W-1:0] E_C    = W'(2**RS + 2**FS);
    localparam logic        [INBITS:0]   MAX_C  = {1'b0, {INBITS{1'b1}}};
    localparam logic        [INBITS:0]   BASE_C = (INBITS+1)'(BASELINE);
    localparam logic        [INBITS:0]   TOT_C  = (INBITS+1)'(TOT_THRESH);
    localparam logic        [INBITS-1:0] IDLE_OUT_C = INBITS'(BASELINE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    // Control state
    state_t              state_r;
    state_t              state_s;
    logic                accept_s;
    logic                reject_s;
    logic                t_ready_r;
    logic                reject_r;
    logic                busy_r;
    logic [W-1:0]        t0_r;
    logic [INBITS-1:0]   amp_r;

    // Group comparisons (all modular, 32-bit signed differences)
    logic [31:0]         req_g0_s;
    logic [31:0]         g0_s;
    logic [31:0]         ahead_diff_s;
    logic [31:0]         start_diff_s;
    logic                req_ahead_s;
    logic                start_reached_s;
    logic                pulse_end_s;

    // Stage 1: per-lane time offsets relative to the pulse start
    logic signed [W-1:0] d_s    [4];
    logic signed [W-1:0] d_s1_r [4];
    logic [31:0]         ltc_s1_r;
    logic                act_s1_r;

    // Stage 2: amplitude shaping, baseline offset, saturation, TOT
    logic [DW-1:0]       mag_s  [4];
    logic [PW-1:0]       prod_s [4];
    logic [INBITS-1:0]   v_s    [4];
    logic [INBITS:0]     sum_s  [4];
    logic [INBITS-1:0]   out_s  [4];
    logic                tot_s  [4];
    logic [INBITS-1:0]   out_r  [4];
    logic                tot_r  [4];
    logic [31:0]         ltc_out_r;

    assign req_g0_s        = req.t_in[W-1:2+RESOLUTION];
    assign g0_s            = t0_r[W-1:2+RESOLUTION];
    assign ahead_diff_s    = req_g0_s - ltc;
    assign start_diff_s    = ltc - g0_s;
    // Start must be strictly in the future; anything 2^31 or more ahead reads as past
    assign req_ahead_s     = (ahead_diff_s[31] == 1'b0) && (ahead_diff_s != 32'd0);
    assign start_reached_s = (start_diff_s[31] == 1'b0);
    // The pulse is finished once a whole group begins at or beyond the pulse end
    assign pulse_end_s     = act_s1_r && (d_s1_r[0] >= E_C);

    // Next-state logic of the request/pulse sequencer
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        reject_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req.t_valid && t_ready_r) begin
                    if (req_ahead_s) begin
                        state_s  = ST_ARMED;
                        accept_s = 1'b1;
                    end else begin
                        state_s  = ST_IDLE;
                        reject_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (start_reached_s) begin
                    state_s = ST_PULSE;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_PULSE: begin
                if (pulse_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_PULSE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, handshake outputs and latched request
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            t_ready_r <= 1'b0;
            reject_r  <= 1'b0;
            busy_r    <= 1'b0;
            t0_r      <= '0;
            amp_r     <= '0;
        end else begin
            state_r   <= state_s;
            t_ready_r <= (state_s == ST_IDLE);
            reject_r  <= reject_s;
            busy_r    <= (state_s != ST_IDLE);
            if (accept_s) begin
                t0_r  <= req.t_in;
                amp_r <= req.amp_in;
            end
        end
    end

    // Offset of each lane's sample time from the pulse start, modulo 2^W
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            d_s[k] = {ltc, 2'(k), {RESOLUTION{1'b0}}} - t0_r;
        end
    end

    // Stage 1 register: offsets, group number, and whether a pulse is in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                d_s1_r[k] <= '0;
            end
            ltc_s1_r <= 32'd0;
            act_s1_r <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                d_s1_r[k] <= d_s[k];
            end
            ltc_s1_r <= ltc;
            act_s1_r <= (state_r != ST_IDLE);
        end
    end

    // Triangle shaping: rise amp*d/P, fall amp*(E-d)/(E-P), baseline add and clip
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            mag_s[k]  = '0;
            prod_s[k] = '0;
            v_s[k]    = '0;
            if (act_s1_r && (d_s1_r[k] > $signed({W{1'b0}})) && (d_s1_r[k] < E_C)) begin
                if (d_s1_r[k] <= P_C) begin
                    mag_s[k]  = DW'(d_s1_r[k]);
                    prod_s[k] = PW'(amp_r) * PW'(mag_s[k]);
                    v_s[k]    = INBITS'(prod_s[k] >> RS);
                end else begin
                    mag_s[k]  = DW'(E_C - d_s1_r[k]);
                    prod_s[k] = PW'(amp_r) * PW'(mag_s[k]);
                    v_s[k]    = INBITS'(prod_s[k] >> FS);
                end
            end else begin
                v_s[k] = '0;
            end
            sum_s[k] = BASE_C + {1'b0, v_s[k]};
            if (sum_s[k] > MAX_C) begin
                out_s[k] = MAX_C[INBITS-1:0];
            end else begin
                out_s[k] = sum_s[k][INBITS-1:0];
            end
            tot_s[k] = ({1'b0, v_s[k]} >= TOT_C);
        end
    end

    // Stage 2 register: samples, TOT flags and their group number
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                out_r[k] <= IDLE_OUT_C;
                tot_r[k] <= 1'b0;
            end
            ltc_out_r <= 32'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                out_r[k] <= out_s[k];
                tot_r[k] <= tot_s[k];
            end
            ltc_out_r <= ltc_s1_r;
        end
    end

    assign req.t_ready = t_ready_r;
    assign req.reject  = reject_r;
    assign busy        = busy_r;
    assign ltc_out     = ltc_out_r;
    assign out_0       = out_r[0];
    assign out_1       = out_r[1];
    assign out_2       = out_r[2];
    assign out_3       = out_r[3];
    assign tot_0       = tot_r[0];
    assign tot_1       = tot_r[1];
    assign tot_2       = tot_r[2];
    assign tot_3       = tot_r[3];

endmodule
